playfield_writer: RTL and testbench

- Owns and updates the 20x10 playfield color array that the background renderer reads to draw settled blocks.
- Accepts a "lock piece" request (four cell coordinates plus a 7-bit shape color) from the game controller and writes those cells into the array.
- Then scans for full rows, removes each one and shifts everything above it down by one row.
- Reports the number of rows cleared and drives the field_color bus continuously.

---
 rtl/playfield_writer.sv | 137 +++++++++++++
 tb/tb_playfield_writer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/playfield_writer.sv
// Playfield color store: writes locked tetromino cells, then removes full rows
// by shifting the rows above them down. Optional macro SCORE_COUNT_EN adds total_lines.
module playfield_writer #(
  parameter int ROWS = 20,
  parameter int COLS = 10,
  parameter int CW   = 7
) (
  input  logic                               Clk,
  input  logic                               Reset,
  input  logic                               lock_valid,
  output logic                               lock_ready,
  input  logic [3:0][4:0]                    cell_row,
  input  logic [3:0][3:0]                    cell_col,
  input  logic [CW-1:0]                      shape,
  input  logic                               clear_all,
  output logic [ROWS-1:0][COLS-1:0][CW-1:0]  field_color,
  output logic                               busy,
  output logic                               lock_done,
  output logic [2:0]                         lines_cleared
`ifdef SCORE_COUNT_EN
  ,
  output logic [15:0]                        total_lines
`endif
);

  localparam logic [4:0] ROWS_L   = 5'(ROWS);
  localparam logic [3:0] COLS_L   = 4'(COLS);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_SCAN,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t           state_reg;
  logic [3:0][4:0]  row_reg;
  logic [3:0][3:0]  col_reg;
  logic [CW-1:0]    shape_reg;
  logic [4:0]       r_reg;
  logic [4:0]       s_reg;
  logic [2:0]       cnt_reg;
  logic [ROWS-1:0]  row_full;

  genvar gi, gj;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      logic [COLS-1:0] nz;
      for (gj = 0; gj < COLS; gj++) begin : g_col
        assign nz[gj] = |field_color[gi][gj];
      end
      assign row_full[gi] = &nz;
    end
  endgenerate

  assign lock_ready = (state_reg == ST_IDLE);
  assign busy       = (state_reg != ST_IDLE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg     <= ST_IDLE;
      field_color   <= '0;
      row_reg       <= '0;
      col_reg       <= '0;
      shape_reg     <= '0;
      r_reg         <= '0;
      s_reg         <= '0;
      cnt_reg       <= '0;
      lock_done     <= 1'b0;
      lines_cleared <= '0;
`ifdef SCORE_COUNT_EN
      total_lines   <= '0;
`endif
    end else begin
      lock_done <= 1'b0;
      if (clear_all) begin
        field_color <= '0;
        state_reg   <= ST_IDLE;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (lock_valid) begin
              row_reg   <= cell_row;
              col_reg   <= cell_col;
              shape_reg <= shape;
              cnt_reg   <= '0;
              state_reg <= ST_WRITE;
            end
          end
          ST_WRITE: begin
            for (int k = 0; k < 4; k++) begin
              if (row_reg[k] < ROWS_L && col_reg[k] < COLS_L)
                field_color[row_reg[k]][col_reg[k]] <= shape_reg;
            end
            r_reg     <= LAST_ROW;
            state_reg <= ST_SCAN;
          end
          ST_SCAN: begin
            if (row_full[r_reg]) begin
              s_reg     <= r_reg;
              state_reg <= ST_SHIFT;
            end else if (r_reg != 5'd0) begin
              r_reg <= r_reg - 5'd1;
            end else begin
              // Pulse is raised on entry so it coincides with the DONE cycle.
              lock_done     <= 1'b1;
              lines_cleared <= cnt_reg;
`ifdef SCORE_COUNT_EN
              total_lines   <= total_lines + 16'(cnt_reg);
`endif
              state_reg     <= ST_DONE;
            end
          end
          ST_SHIFT: begin
            if (s_reg != 5'd0) begin
              field_color[s_reg] <= field_color[s_reg - 5'd1];
              s_reg              <= s_reg - 5'd1;
            end else begin
              // r stays put: the row that just dropped into r must be re-checked.
              field_color[0] <= '0;
              if (cnt_reg != 3'd7)
                cnt_reg <= cnt_reg + 3'd1;
              state_reg <= ST_SCAN;
            end
          end
          ST_DONE: begin
            state_reg <= ST_IDLE;
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_playfield_writer.sv
// Directed bench for playfield_writer: lock, row clear, range drop, abort paths.
module tb_playfield_writer;

  logic                       Clk;
  logic                       Reset;
  logic                       lock_valid;
  logic                       lock_ready;
  logic [3:0][4:0]            cell_row;
  logic [3:0][3:0]            cell_col;
  logic [6:0]                 shape;
  logic                       clear_all;
  logic [19:0][9:0][6:0]      field_color;
  logic                       busy;
  logic                       lock_done;
  logic [2:0]                 lines_cleared;
`ifdef SCORE_COUNT_EN
  logic [15:0]                total_lines;
`endif

  int tests = 0;
  int fails = 0;
  logic [6:0] exp_field [20][10];

  playfield_writer dut (
    .Clk(Clk), .Reset(Reset), .lock_valid(lock_valid), .lock_ready(lock_ready),
    .cell_row(cell_row), .cell_col(cell_col), .shape(shape), .clear_all(clear_all),
    .field_color(field_color), .busy(busy), .lock_done(lock_done),
    .lines_cleared(lines_cleared)
`ifdef SCORE_COUNT_EN
    , .total_lines(total_lines)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic int field_diff();
    int n = 0;
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++)
        if (field_color[r][c] !== exp_field[r][c]) n++;
    return n;
  endfunction

  task automatic clear_exp();
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++)
        exp_field[r][c] = 7'h00;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (lock_ready !== 1'b1 && n < 100) begin
      @(posedge Clk); #1; n++;
    end
  endtask

  // Returns one cycle after the acceptance edge (cycle 1 = WRITE).
  task automatic start_lock(input logic [3:0][4:0] rr, input logic [3:0][3:0] cc,
                            input logic [6:0] sh);
    wait_ready();
    cell_row = rr; cell_col = cc; shape = sh; lock_valid = 1'b1;
    @(posedge Clk); #1;
    lock_valid = 1'b0;
  endtask

  task automatic do_lock(input logic [3:0][4:0] rr, input logic [3:0][3:0] cc,
                         input logic [6:0] sh, output int lat);
    start_lock(rr, cc, sh);
    lat = 1;
    while (lock_done !== 1'b1 && lat < 500) begin
      @(posedge Clk); #1; lat++;
    end
    $display("[TB] lock shape=%h latency=%0d lines=%0d", sh, lat, lines_cleared);
  endtask

  task automatic do_clear();
    wait_ready();
    clear_all = 1'b1;
    @(posedge Clk); #1;
    clear_all = 1'b0;
  endtask

  task automatic test_reset();
    clear_exp();
    tests++; if (field_diff() !== 0) begin fails++; $display("FAIL reset_field cells_differ=%0d required=0", field_diff()); end
    tests++; if (lock_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b required=1", lock_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b required=0", busy); end
    tests++; if (lock_done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b required=0", lock_done); end
    tests++; if (lines_cleared !== 3'd0) begin fails++; $display("FAIL reset_lines got=%0d required=0", lines_cleared); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_basic_lock();
    int lat;
    clear_exp();
    for (int c = 0; c < 4; c++) exp_field[19][c] = 7'h05;
    do_lock({5'd19, 5'd19, 5'd19, 5'd19}, {4'd3, 4'd2, 4'd1, 4'd0}, 7'h05, lat);
    tests++; if (lat !== 22) begin fails++; $display("FAIL basic_latency got=%0d required=22", lat); end
    tests++; if (lines_cleared !== 3'd0) begin fails++; $display("FAIL basic_lines got=%0d required=0", lines_cleared); end
    tests++; if (field_diff() !== 0) begin fails++; $display("FAIL basic_field cells_differ=%0d required=0", field_diff()); end
  endtask

  task automatic test_single_clear();
    int lat;
    do_clear();
    do_lock({5'd19, 5'd19, 5'd19, 5'd19}, {4'd3, 4'd2, 4'd1, 4'd0}, 7'h01, lat);
    do_lock({5'd18, 5'd18, 5'd19, 5'd19}, {4'd1, 4'd0, 4'd5, 4'd4}, 7'h03, lat);
    do_lock({5'd19, 5'd19, 5'd19, 5'd19}, {4'd9, 4'd8, 4'd7, 4'd6}, 7'h02, lat);
    clear_exp();
    exp_field[19][0] = 7'h03;
    exp_field[19][1] = 7'h03;
    tests++; if (lat !== 43) begin fails++; $display("FAIL clear1_latency got=%0d required=43", lat); end
    tests++; if (lines_cleared !== 3'd1) begin fails++; $display("FAIL clear1_lines got=%0d required=1", lines_cleared); end
    tests++; if (field_diff() !== 0) begin fails++; $display("FAIL clear1_field cells_differ=%0d required=0", field_diff()); end
  endtask

  task automatic test_tetris();
    int lat;
    logic [4:0] r5;
    do_clear();
    do_lock({5'd15, 5'd15, 5'd15, 5'd15}, {4'd0, 4'd0, 4'd0, 4'd0}, 7'h04, lat);
    do_lock({5'd14, 5'd14, 5'd14, 5'd14}, {4'd5, 4'd5, 4'd5, 4'd5}, 7'h06, lat);
    for (int r = 16; r < 20; r++) begin
      r5 = 5'(r);
      do_lock({r5, r5, r5, r5}, {4'd3, 4'd2, 4'd1, 4'd0}, 7'h07, lat);
      do_lock({r5, r5, r5, r5}, {4'd7, 4'd6, 4'd5, 4'd4}, 7'h08, lat);
    end
    do_lock({5'd19, 5'd18, 5'd17, 5'd16}, {4'd8, 4'd8, 4'd8, 4'd8}, 7'h09, lat);
    do_lock({5'd19, 5'd18, 5'd17, 5'd16}, {4'd9, 4'd9, 4'd9, 4'd9}, 7'h01, lat);
    clear_exp();
    exp_field[19][0] = 7'h04;
    exp_field[18][5] = 7'h06;
    tests++; if (lines_cleared !== 3'd4) begin fails++; $display("FAIL tetris_lines got=%0d required=4", lines_cleared); end
    tests++; if (field_diff() !== 0) begin fails++; $display("FAIL tetris_field cells_differ=%0d required=0", field_diff()); end
  endtask

  task automatic test_out_of_range();
    int lat;
    do_clear();
    do_lock({5'd0, 5'd10, 5'd5, 5'd20}, {4'd9, 4'd4, 4'd12, 4'd3}, 7'h11, lat);
    clear_exp();
    exp_field[10][4] = 7'h11;
    exp_field[0][9]  = 7'h11;
    tests++; if (lat !== 22) begin fails++; $display("FAIL oor_latency got=%0d required=22", lat); end
    tests++; if (lines_cleared !== 3'd0) begin fails++; $display("FAIL oor_lines got=%0d required=0", lines_cleared); end
    tests++; if (field_diff() !== 0) begin fails++; $display("FAIL oor_field cells_differ=%0d required=0", field_diff()); end
  endtask

  task automatic test_abort();
    int lat;
    int seen;
    do_clear();
    do_lock({5'd19, 5'd19, 5'd19, 5'd19}, {4'd3, 4'd2, 4'd1, 4'd0}, 7'h01, lat);
    do_lock({5'd19, 5'd19, 5'd19, 5'd19}, {4'd7, 4'd6, 4'd5, 4'd4}, 7'h01, lat);
    start_lock({5'd19, 5'd19, 5'd19, 5'd19}, {4'd9, 4'd8, 4'd9, 4'd8}, 7'h02);
    repeat (4) begin @(posedge Clk); #1; end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL abort_busy_before got=%b required=1", busy); end
    clear_all = 1'b1;
    @(posedge Clk); #1;
    clear_all = 1'b0;
    clear_exp();
    tests++; if (field_diff() !== 0) begin fails++; $display("FAIL abort_field cells_differ=%0d required=0", field_diff()); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got=%b required=0", busy); end
    seen = 0;
    repeat (40) begin
      if (lock_done === 1'b1) seen++;
      @(posedge Clk); #1;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL abort_no_done got=%0d pulses required=0", seen); end
    $display("[TB] clear_all during SHIFT done");

    start_lock({5'd19, 5'd19, 5'd19, 5'd19}, {4'd0, 4'd0, 4'd0, 4'd0}, 7'h05);
    repeat (9) begin @(posedge Clk); #1; end
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    tests++; if (field_diff() !== 0) begin fails++; $display("FAIL rst_mid_field cells_differ=%0d required=0", field_diff()); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got=%b required=0", busy); end
    tests++; if (lock_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_ready got=%b required=1", lock_ready); end
    tests++; if (lock_done !== 1'b0) begin fails++; $display("FAIL rst_mid_done got=%b required=0", lock_done); end
    $display("[TB] Reset during SCAN done");
  endtask

  task automatic test_clear_priority();
    int lat;
    do_lock({5'd0, 5'd0, 5'd0, 5'd0}, {4'd0, 4'd0, 4'd0, 4'd0}, 7'h09, lat);
    wait_ready();
    cell_row = {5'd5, 5'd5, 5'd5, 5'd5};
    cell_col = {4'd5, 4'd5, 4'd5, 4'd5};
    shape = 7'h0a; lock_valid = 1'b1; clear_all = 1'b1;
    @(posedge Clk); #1;
    lock_valid = 1'b0; clear_all = 1'b0;
    clear_exp();
    tests++; if (field_diff() !== 0) begin fails++; $display("FAIL prio_field cells_differ=%0d required=0", field_diff()); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL prio_busy got=%b required=0", busy); end
    $display("[TB] clear_all priority done");
  endtask

`ifdef SCORE_COUNT_EN
  task automatic test_score();
    int lat;
    logic [4:0] r5;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    do_lock({5'd19, 5'd19, 5'd19, 5'd19}, {4'd3, 4'd2, 4'd1, 4'd0}, 7'h01, lat);
    do_lock({5'd19, 5'd19, 5'd19, 5'd19}, {4'd7, 4'd6, 4'd5, 4'd4}, 7'h01, lat);
    do_lock({5'd19, 5'd19, 5'd19, 5'd19}, {4'd9, 4'd8, 4'd9, 4'd8}, 7'h01, lat);
    do_lock({5'd0, 5'd0, 5'd0, 5'd0}, {4'd0, 4'd0, 4'd0, 4'd0}, 7'h02, lat);
    for (int r = 18; r < 20; r++) begin
      r5 = 5'(r);
      do_lock({r5, r5, r5, r5}, {4'd3, 4'd2, 4'd1, 4'd0}, 7'h03, lat);
      do_lock({r5, r5, r5, r5}, {4'd7, 4'd6, 4'd5, 4'd4}, 7'h03, lat);
    end
    do_lock({5'd19, 5'd19, 5'd18, 5'd18}, {4'd9, 4'd8, 4'd9, 4'd8}, 7'h04, lat);
    tests++; if (lines_cleared !== 3'd2) begin fails++; $display("FAIL score_lines got=%0d required=2", lines_cleared); end
    tests++; if (total_lines !== 16'd3) begin fails++; $display("FAIL score_total got=%0d required=3", total_lines); end
  endtask
`endif

  initial begin
    Reset = 1'b1; lock_valid = 1'b0; clear_all = 1'b0;
    cell_row = '0; cell_col = '0; shape = '0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    test_reset();
    test_basic_lock();
    test_single_clear();
    test_tetris();
    test_out_of_range();
    test_abort();
    test_clear_priority();
`ifdef SCORE_COUNT_EN
    test_score();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
